// File: rtl/vdp_vram_ctrl.sv
// VDP video RAM sequencer: CPU port decode, write FIFO, read-ahead buffer and
// a single-port RAM arbiter in which the raster fetch always wins.
//
// state  | meaning
// IDLE   | pick next access: video, then FIFO write, then read-ahead
// VID    | video fetch address on the RAM; ack follows next clk
// CPU_WR | FIFO head written to the RAM for one clk
// CPU_RD | read-ahead address on the RAM; data captured next clk

module vdp_vram_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_wr_stb,
  input  logic              cpu_rd_stb,
  input  logic              cpu_port,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_busy,
  output logic              overflow,
  output logic              reg_we,
  output logic [2:0]        reg_num,
  output logic [7:0]        reg_data,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  input  logic [7:0]        vram_rdata
);

  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, VID, CPU_WR, CPU_RD} state_t;

  state_t state, state_nxt;

  logic              flag;
  logic [7:0]        byte_lo;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] set_ptr;
  logic [ADDR_W-1:0] sched_addr;
  logic [13:0]       addr14;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full, fifo_empty;

  logic [ADDR_W-1:0] ra_addr;
  logic [7:0]        ra_data;
  logic              ra_pending, ra_valid, ra_redo;

  logic              vid_ack_q, rd_cap_q;

  logic wr_acc, rd_acc;
  logic ctrl_wr, data_wr, ctrl_rd, data_rd;
  logic set_addr, set_reg, read_mode_set;
  logic push, pop, sched;

  // A write strobe shadows a simultaneous read strobe.
  assign wr_acc  = cpu_wr_stb;
  assign rd_acc  = cpu_rd_stb & ~cpu_wr_stb;
  assign ctrl_wr = wr_acc &  cpu_port;
  assign data_wr = wr_acc & ~cpu_port;
  assign ctrl_rd = rd_acc &  cpu_port;
  assign data_rd = rd_acc & ~cpu_port;

  assign set_reg       = ctrl_wr & flag &  cpu_wdata[7];
  assign set_addr      = ctrl_wr & flag & ~cpu_wdata[7];
  assign read_mode_set = set_addr & ~cpu_wdata[6];

  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = data_wr & ~fifo_full;
  assign pop        = (state == CPU_WR) & ~fifo_empty;
  assign sched      = read_mode_set | data_rd;

  assign addr14     = {cpu_wdata[5:0], byte_lo};
  assign set_ptr    = ADDR_W'(addr14);
  assign ptr_inc    = ptr + ADDR_W'(1);
  assign sched_addr = read_mode_set ? set_ptr : ptr_inc;

  assign cpu_busy  = fifo_full | ra_pending;
  assign vid_ack   = vid_ack_q;
  assign vid_rdata = vid_ack_q ? vram_rdata : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag      <= 1'b0;
      byte_lo   <= 8'h00;
      ptr       <= '0;
      overflow  <= 1'b0;
      cpu_rdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_num   <= 3'd0;
      reg_data  <= 8'h00;
    end else begin
      reg_we <= set_reg;
      if (wr_acc | rd_acc)
        flag <= ctrl_wr & ~flag;
      if (ctrl_wr & ~flag)
        byte_lo <= cpu_wdata;
      if (set_reg) begin
        reg_num  <= cpu_wdata[2:0];
        reg_data <= byte_lo;
      end
      if (set_addr)
        ptr <= set_ptr;
      else if (push | data_rd)
        ptr <= ptr_inc;
      if (ctrl_rd)
        overflow <= 1'b0;
      else if (data_wr & fifo_full)
        overflow <= 1'b1;
      if (ctrl_rd)
        cpu_rdata <= {overflow, 7'b0};
      else if (data_rd)
        cpu_rdata <= ra_valid ? ra_data : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
    end else if (read_mode_set) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_idx <= wr_idx + IDX_W'(1);
      if (pop)
        rd_idx <= rd_idx + IDX_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_idx] <= ptr;
      fifo_data[wr_idx] <= cpu_wdata;
    end
  end

  // A reschedule that lands while the old fetch is in flight makes that
  // fetch stale; ra_redo discards its data so the new address is fetched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra_addr    <= '0;
      ra_data    <= 8'h00;
      ra_pending <= 1'b0;
      ra_valid   <= 1'b0;
      ra_redo    <= 1'b0;
    end else if (sched) begin
      ra_addr    <= sched_addr;
      ra_pending <= 1'b1;
      ra_valid   <= 1'b0;
      ra_redo    <= (state == CPU_RD);
    end else if (rd_cap_q) begin
      if (ra_redo) begin
        ra_redo <= 1'b0;
      end else begin
        ra_data    <= vram_rdata;
        ra_valid   <= 1'b1;
        ra_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vid_ack_q <= 1'b0;
      rd_cap_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      vid_ack_q <= (state == VID);
      rd_cap_q  <= (state == CPU_RD);
    end
  end

  // The ack cycle grants nothing: vid_req is still the old request there,
  // and a requester that re-asserts at once keeps the RAM to itself.
  always_comb begin
    state_nxt  = state;
    vram_addr  = '0;
    vram_wdata = 8'h00;
    vram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (vid_ack_q)
          state_nxt = IDLE;
        else if (vid_req)
          state_nxt = VID;
        else if (!fifo_empty)
          state_nxt = CPU_WR;
        else if (ra_pending && !rd_cap_q)
          state_nxt = CPU_RD;
      end
      VID: begin
        vram_addr = vid_addr;
        state_nxt = IDLE;
      end
      CPU_WR: begin
        vram_addr  = fifo_addr[rd_idx];
        vram_wdata = fifo_data[rd_idx];
        vram_we    = ~fifo_empty;
        state_nxt  = IDLE;
      end
      CPU_RD: begin
        vram_addr = ra_addr;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
